// File: rtl/ins_line_cache.sv
// ins_line_cache -- direct-mapped instruction line cache with DDR burst refill.
//
// A fetch is accepted in IDLE, resolved in LOOKUP (interrupt vector, hit or
// miss), refilled from DDR one full line at a time on a miss, and answered
// with a one-cycle ins_valid strobe. instruction holds its value between strobes.
//
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   fetch_req, addr_ins      fetch request / word address (taken when ins_cache_rdy=1)
//   flush                    invalidate all lines (deferred while a refill is in flight)
//   int_ins                  word returned for fetches of INT_VEC_ADDR
//   ins_cache_rdy            ready to accept a fetch
//   instruction, ins_valid   fetched word and its one-cycle qualifier
//   ISA_read_req/addr, isa_read_len   DDR burst request (zero outside a refill)
//   instruction_to_cache, rd_burst_data_valid   DDR burst beats
//   hit_cnt, miss_cnt        saturating lookup counters, present only when
//                            ICACHE_PERF_CNT_EN is defined
module ins_line_cache #(
    parameter int ADDR_WIDTH_MEM = 16,
    parameter int ISA_WIDTH      = 30,
    parameter int DDR_ADDR_WIDTH = 28,
    parameter int LINE_WORDS     = 16,
    parameter int NUM_LINES      = 4,
    parameter int DDR_SHIFT      = 3,
    parameter logic [ADDR_WIDTH_MEM-1:0] INT_VEC_ADDR = 16'h8000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      fetch_req,
    input  logic [ADDR_WIDTH_MEM-1:0] addr_ins,
    input  logic                      flush,
    input  logic [ISA_WIDTH-1:0]      int_ins,
    output logic                      ins_cache_rdy,
    output logic [ISA_WIDTH-1:0]      instruction,
    output logic                      ins_valid,
    output logic                      ISA_read_req,
    output logic [DDR_ADDR_WIDTH-1:0] ISA_read_addr,
    output logic [9:0]                isa_read_len,
    input  logic [ISA_WIDTH-1:0]      instruction_to_cache,
    input  logic                      rd_burst_data_valid
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]               hit_cnt,
    output logic [31:0]               miss_cnt
`endif
);

    localparam int OFF_W   = $clog2(LINE_WORDS);
    localparam int LOG_NL  = $clog2(NUM_LINES);
    localparam int IDX_W   = (LOG_NL > 0) ? LOG_NL : 1;
    localparam int TAG_LSB = OFF_W + LOG_NL;
    localparam int TAG_W   = ADDR_WIDTH_MEM - TAG_LSB;

    typedef enum logic [1:0] {IDLE, LOOKUP, REFILL, RESP} state_t;

    state_t                     state_q, state_d;
    logic [ADDR_WIDTH_MEM-1:0]  addr_q;
    logic                       rdy_q;
    logic [ISA_WIDTH-1:0]       instr_q;
    logic                       ival_q;
    logic [OFF_W-1:0]           beat_q;
    logic                       pend_q;
    logic [NUM_LINES-1:0]       line_vld_q;
    logic [TAG_W-1:0]           tag_q [NUM_LINES];
    logic [ISA_WIDTH-1:0]       mem   [NUM_LINES][LINE_WORDS];

    logic [OFF_W-1:0]           offset;
    logic [IDX_W-1:0]           idx;
    logic [TAG_W-1:0]           tag;
    logic [ADDR_WIDTH_MEM-1:0]  line_base;
    logic                       is_int, hit, beat_fire, last_beat, clr_all;

    assign offset    = addr_q[OFF_W-1:0];
    // A single-line cache has no index bits; every address maps to line 0.
    assign idx       = (NUM_LINES > 1) ? IDX_W'(addr_q >> OFF_W) : '0;
    assign tag       = TAG_W'(addr_q >> TAG_LSB);
    assign line_base = {addr_q[ADDR_WIDTH_MEM-1:OFF_W], {OFF_W{1'b0}}};
    assign is_int    = (addr_q == INT_VEC_ADDR);
    assign hit       = line_vld_q[idx] && (tag_q[idx] == tag);
    assign beat_fire = (state_q == REFILL) && rd_burst_data_valid;
    assign last_beat = beat_fire && (beat_q == OFF_W'(LINE_WORDS - 1));
    // A flush seen during REFILL/RESP is held in pend_q and takes effect in
    // the first IDLE cycle, so the line just refilled is dropped as well.
    assign clr_all   = ((state_q == IDLE) && pend_q) ||
                       (((state_q == IDLE) || (state_q == LOOKUP)) && flush);

    assign ins_cache_rdy = rdy_q;
    assign instruction   = instr_q;
    assign ins_valid     = ival_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Burst outputs are decoded from state so that an asynchronous reset
    // drops ISA_read_req immediately.
    always_comb begin
        state_d       = state_q;
        ISA_read_req  = 1'b0;
        ISA_read_addr = '0;
        isa_read_len  = '0;
        case (state_q)
            IDLE:   if (rdy_q && fetch_req) state_d = LOOKUP;
            LOOKUP: state_d = (is_int || hit) ? IDLE : REFILL;
            REFILL: begin
                ISA_read_req  = 1'b1;
                ISA_read_addr = DDR_ADDR_WIDTH'(line_base) << DDR_SHIFT;
                isa_read_len  = 10'(LINE_WORDS);
                if (last_beat) state_d = RESP;
            end
            RESP:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q     <= '0;
            rdy_q      <= 1'b0;
            instr_q    <= '0;
            ival_q     <= 1'b0;
            beat_q     <= '0;
            pend_q     <= 1'b0;
            line_vld_q <= '0;
            for (int i = 0; i < NUM_LINES; i++) tag_q[i] <= '0;
        end else begin
            // Ready only while the next state is IDLE; this keeps it low
            // during reset and for the first cycle after release.
            rdy_q  <= (state_d == IDLE);
            ival_q <= 1'b0;
            if ((state_q == IDLE) && rdy_q && fetch_req) addr_q <= addr_ins;

            if (state_q == LOOKUP) begin
                if (is_int) begin
                    instr_q <= int_ins;
                    ival_q  <= 1'b1;
                end else if (hit) begin
                    instr_q <= mem[idx][offset];
                    ival_q  <= 1'b1;
                end
            end else if (state_q == RESP) begin
                instr_q <= mem[idx][offset];
                ival_q  <= 1'b1;
            end

            if (beat_fire) beat_q <= last_beat ? '0 : beat_q + 1'b1;

            if (clr_all) begin
                line_vld_q <= '0;
            end else if (last_beat) begin
                line_vld_q[idx] <= 1'b1;
                tag_q[idx]      <= tag;
            end

            if (((state_q == REFILL) || (state_q == RESP)) && flush) pend_q <= 1'b1;
            else if (state_q == IDLE)                                pend_q <= 1'b0;
        end
    end

    // Data array has no reset; contents are only trusted under a valid bit.
    always_ff @(posedge clk) begin
        if (beat_fire) mem[idx][beat_q] <= instruction_to_cache;
    end

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if ((state_q == LOOKUP) && !is_int) begin
            if (hit) begin
                if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 1'b1;
            end else begin
                if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_ins_line_cache.sv
// Randomized scoreboard bench for ins_line_cache (default build).
// The driver acts as both the fetch source and the DDR responder and pushes
// the expected response of each fetch into a queue; a separate monitor pops
// and compares on every ins_valid strobe.
module tb_ins_line_cache;

    localparam int LW = 16;
    localparam int NL = 4;
    localparam logic [15:0] INTV = 16'h8000;

    logic        clk = 1'b0, rst = 1'b0;
    logic        fetch_req = 1'b0, flush = 1'b0, rd_burst_data_valid = 1'b0;
    logic [15:0] addr_ins = '0;
    logic [29:0] int_ins = '0, instruction_to_cache = '0;
    logic        ins_cache_rdy, ins_valid, ISA_read_req;
    logic [29:0] instruction;
    logic [27:0] ISA_read_addr;
    logic [9:0]  isa_read_len;

    ins_line_cache dut (
        .clk(clk), .rst(rst), .fetch_req(fetch_req), .addr_ins(addr_ins),
        .flush(flush), .int_ins(int_ins), .ins_cache_rdy(ins_cache_rdy),
        .instruction(instruction), .ins_valid(ins_valid),
        .ISA_read_req(ISA_read_req), .ISA_read_addr(ISA_read_addr),
        .isa_read_len(isa_read_len), .instruction_to_cache(instruction_to_cache),
        .rd_burst_data_valid(rd_burst_data_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: which line holds which tag, and what the line contains.
    typedef struct { logic [29:0] val; int lat; int t0; } exp_t;
    exp_t        sbq[$];
    bit          mv [NL];
    logic [9:0]  mt [NL];
    logic [29:0] md [NL][LW];
    int          salt_n = 0;

    task automatic model_clear();
        for (int i = 0; i < NL; i++) mv[i] = 1'b0;
    endtask

    // Monitor
    exp_t        mon_e;
    logic [29:0] last_instr = '0;
    always @(negedge clk) begin
        if (!rst) begin
            last_instr = '0;
        end else if (ins_valid) begin
            if (sbq.size() == 0) begin
                chk("unexpected ins_valid", ins_valid, 1'b0);
            end else begin
                mon_e = sbq.pop_front();
                chk("instruction", instruction, mon_e.val);
                if (mon_e.lat >= 0) chk("hit latency", cyc - mon_e.t0, mon_e.lat);
            end
            last_instr = instruction;
        end else begin
            chk("instruction hold", instruction, last_instr);
        end
    end

    task automatic wait_rdy();
        int k = 0;
        while (!ins_cache_rdy && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!ins_cache_rdy) chk("ready timeout", ins_cache_rdy, 1'b1);
    endtask

    task automatic flush_idle();
        @(negedge clk);
        wait_rdy();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        model_clear();
    endtask

    task automatic stray_beat();
        @(negedge clk);
        rd_burst_data_valid  = 1'b1;
        instruction_to_cache = 30'($urandom);
        @(negedge clk);
        rd_burst_data_valid  = 1'b0;
    endtask

    // flush_beat: beat index carrying a flush pulse (-1 none)
    // flush_lk:   pulse flush while the fetch is in lookup
    // abort_beat: assert reset instead of sending this beat (-1 none)
    task automatic do_fetch(input logic [15:0] a, input int flush_beat,
                            input bit flush_lk, input int abort_beat);
        int          k, idx;
        bit          is_int, miss;
        logic [3:0]  off;
        logic [9:0]  tg;
        logic [29:0] salt, ev;
        logic [27:0] exp_addr;
        off = a[3:0];
        idx = int'(a[5:4]);
        tg  = a[15:6];
        @(negedge clk);
        wait_rdy();
        is_int = (a == INTV);
        miss   = !is_int && !(mv[idx] && mt[idx] == tg);
        salt   = 30'(salt_n) << 8;
        if (miss) salt_n++;
        ev = is_int ? int_ins : (miss ? salt + 30'(off) : md[idx][off]);
        if (abort_beat < 0) sbq.push_back('{ev, miss ? -1 : 2, cyc});
        fetch_req = 1'b1;
        addr_ins  = a;
        @(negedge clk);
        fetch_req = 1'b0;
        addr_ins  = 16'($urandom);
        if (flush_lk) begin
            flush = 1'b1;
            model_clear();
        end
        @(negedge clk);
        flush = 1'b0;
        if (!miss) begin
            chk("no DDR request on hit", ISA_read_req, 1'b0);
            return;
        end
        k = 0;
        while (!ISA_read_req && k < 8) begin
            @(negedge clk);
            k++;
        end
        exp_addr = 28'({a[15:4], 4'h0}) << 3;
        chk("read request", ISA_read_req, 1'b1);
        chk("read addr", ISA_read_addr, exp_addr);
        chk("read len", isa_read_len, 10'd16);
        for (int b = 0; b < LW; b++) begin
            if (b == abort_beat) begin
                #2 rst = 1'b0;
                #1;
                chk("reset drops read req", ISA_read_req, 1'b0);
                chk("reset read addr", ISA_read_addr, 28'd0);
                chk("reset read len", isa_read_len, 10'd0);
                chk("reset rdy", ins_cache_rdy, 1'b0);
                chk("reset ins_valid", ins_valid, 1'b0);
                chk("reset instruction", instruction, 30'd0);
                repeat (3) @(negedge clk);
                rst = 1'b1;
                model_clear();
                return;
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if (b == LW - 1) chk("read req held", ISA_read_req, 1'b1);
            rd_burst_data_valid  = 1'b1;
            instruction_to_cache = salt + 30'(b);
            if (b == flush_beat) flush = 1'b1;
            @(negedge clk);
            rd_burst_data_valid  = 1'b0;
            flush                = 1'b0;
            instruction_to_cache = 30'($urandom);
        end
        chk("read req drop after last beat", ISA_read_req, 1'b0);
        mv[idx] = 1'b1;
        mt[idx] = tg;
        for (int w = 0; w < LW; w++) md[idx][w] = salt + 30'(w);
        if (flush_beat >= 0) model_clear();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        logic [15:0] a;
        model_clear();
        repeat (3) @(negedge clk);
        chk("reset rdy", ins_cache_rdy, 1'b0);
        chk("reset ins_valid", ins_valid, 1'b0);
        chk("reset instruction", instruction, 30'd0);
        chk("reset read req", ISA_read_req, 1'b0);
        chk("reset read addr", ISA_read_addr, 28'd0);
        chk("reset read len", isa_read_len, 10'd0);
        rst = 1'b1;

        // Directed sequence: cold miss, hit, conflict miss, re-miss, interrupt vector.
        do_fetch(16'h0012, -1, 1'b0, -1);
        do_fetch(16'h001F, -1, 1'b0, -1);
        do_fetch(16'h0052, -1, 1'b0, -1);
        do_fetch(16'h0012, -1, 1'b0, -1);
        int_ins = 30'h1234567;
        do_fetch(INTV, -1, 1'b0, -1);
        do_fetch(16'h0013, -1, 1'b0, -1);
        // Flush during refill: word still returned, line dropped afterwards.
        flush_idle();
        do_fetch(16'h0012, 5, 1'b0, -1);
        do_fetch(16'h0012, -1, 1'b0, -1);
        do_fetch(16'h0015, -1, 1'b1, -1);
        do_fetch(16'h0015, -1, 1'b0, -1);

        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 99);
            if (r < 6) begin
                flush_idle();
            end else if (r < 12) begin
                stray_beat();
            end else if (r < 22) begin
                int_ins = 30'($urandom);
                do_fetch(INTV, -1, ($urandom_range(0, 9) == 0), -1);
            end else begin
                a = {10'($urandom_range(0, 2)), 2'($urandom), 4'($urandom)};
                do_fetch(a, ($urandom_range(0, 9) == 0) ? $urandom_range(0, LW - 1) : -1,
                         ($urandom_range(0, 12) == 0), -1);
            end
        end

        // Reset in the middle of a refill, then the same address must miss.
        flush_idle();
        do_fetch(16'h0012, -1, 1'b0, 8);
        do_fetch(16'h0012, -1, 1'b0, -1);
        do_fetch(16'h001A, -1, 1'b0, -1);

        repeat (10) @(negedge clk);
        chk("scoreboard drained", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
